// File: rtl/controller_event_encoder_pkg.sv
// Shared constants for the gamepad event encoder: pad bit map, event layout, FSM states.
package controller_event_encoder_pkg;

  localparam int unsigned NUM_ACTIONS = 5;
  localparam int unsigned EVENT_W     = 2 * NUM_ACTIONS;

  // Serial bit positions of the buttons we care about (others are read and dropped)
  localparam int unsigned BTN_B     = 0;
  localparam int unsigned BTN_UP    = 4;
  localparam int unsigned BTN_DOWN  = 5;
  localparam int unsigned BTN_LEFT  = 6;
  localparam int unsigned BTN_RIGHT = 7;
  localparam int unsigned BTN_A     = 8;

  // Action bit positions inside each 5-bit half of input_data
  localparam int unsigned EV_UP        = 0;
  localparam int unsigned EV_DOWN      = 1;
  localparam int unsigned EV_LEFT      = 2;
  localparam int unsigned EV_RIGHT     = 3;
  localparam int unsigned EV_ATTACK    = 4;
  localparam int unsigned EV_PRESS_OFS = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_CLK_HI = 3'd2,
    ST_CLK_LO = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // One-hot action mask for a given serial bit index; B and A share attack
  function automatic logic [NUM_ACTIONS-1:0] btn_to_action(input int unsigned idx);
    logic [NUM_ACTIONS-1:0] act;
    act = '0;
    case (idx)
      BTN_UP:       act[EV_UP]     = 1'b1;
      BTN_DOWN:     act[EV_DOWN]   = 1'b1;
      BTN_LEFT:     act[EV_LEFT]   = 1'b1;
      BTN_RIGHT:    act[EV_RIGHT]  = 1'b1;
      BTN_B, BTN_A: act[EV_ATTACK] = 1'b1;
      default:      act            = '0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/controller_event_encoder_pad_phase_timer.sv
// Loadable down-counter timing the latch and pad-clock phases; pulses on the last cycle of a phase.
module controller_event_encoder_pad_phase_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         phase_done
);

  logic [W-1:0] count;

  // Count down to zero; phase_done is registered so it lines up with count reaching zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      count      <= '0;
      phase_done <= 1'b0;
    end else if (load) begin
      count      <= load_val;
      phase_done <= (load_val == '0);
    end else begin
      count      <= (count != '0) ? count - W'(1) : count;
      phase_done <= (count == W'(1));
    end
  end

endmodule

// File: rtl/controller_event_encoder.sv
// Reads an SNES-style serial pad once per poll and emits one-cycle press/release events.
module controller_event_encoder
  import controller_event_encoder_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 6,
  parameter int unsigned NUM_BITS = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   poll,
  input  logic                   pad_data,
  output logic                   pad_latch,
  output logic                   pad_clk,
  output logic [EVENT_W-1:0]     input_data,
  output logic [NUM_ACTIONS-1:0] buttons,
  output logic                   busy,
  output logic                   valid
);

  localparam int unsigned PH_W  = $clog2(2 * CLK_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_BITS + 1);

  localparam logic [PH_W-1:0]  LATCH_LEN = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  HALF_LEN  = PH_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BITS - 1);

  state_t                 state;
  logic [IDX_W-1:0]       index;
  logic [NUM_ACTIONS-1:0] cur_q;
  logic [NUM_ACTIONS-1:0] prev_q;
  logic                   phase_done;
  logic                   timer_load_c;
  logic [PH_W-1:0]        timer_val_c;

  controller_event_encoder_pad_phase_timer #(
    .W(PH_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load_c),
    .load_val   (timer_val_c),
    .phase_done (phase_done)
  );

  // Start the next phase timer on poll accept and at each phase boundary except the last
  always_comb begin
    timer_load_c = 1'b0;
    timer_val_c  = '0;
    case (state)
      ST_IDLE: begin
        timer_load_c = poll;
        timer_val_c  = LATCH_LEN;
      end
      ST_LATCH, ST_CLK_HI: begin
        timer_load_c = phase_done;
        timer_val_c  = HALF_LEN;
      end
      ST_CLK_LO: begin
        timer_load_c = phase_done && (index != LAST_IDX);
        timer_val_c  = HALF_LEN;
      end
      default: begin
        timer_load_c = 1'b0;
        timer_val_c  = '0;
      end
    endcase
  end

  // Pad read sequencer with registered pad pins and event outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      index      <= '0;
      cur_q      <= '0;
      prev_q     <= '0;
      pad_latch  <= 1'b0;
      pad_clk    <= 1'b1;
      input_data <= '0;
      buttons    <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (poll) begin
            state     <= ST_LATCH;
            pad_latch <= 1'b1;
            busy      <= 1'b1;
            index     <= '0;
            cur_q     <= '0;
          end
        end
        ST_LATCH: begin
          if (phase_done) begin
            state     <= ST_CLK_HI;
            pad_latch <= 1'b0;
          end
        end
        ST_CLK_HI: begin
          // Pad data is active-low; accumulate pressed bits into the action mask
          if (phase_done) begin
            cur_q   <= cur_q | (btn_to_action(32'(index)) & {NUM_ACTIONS{~pad_data}});
            pad_clk <= 1'b0;
            state   <= ST_CLK_LO;
          end
        end
        ST_CLK_LO: begin
          if (phase_done) begin
            pad_clk <= 1'b1;
            index   <= index + IDX_W'(1);
            if (index == LAST_IDX) begin
              state   <= ST_DONE;
              busy    <= 1'b0;
              valid   <= 1'b1;
              input_data[EV_PRESS_OFS +: NUM_ACTIONS] <= cur_q & ~prev_q;
              input_data[NUM_ACTIONS-1:0]             <= ~cur_q & prev_q;
              buttons <= cur_q;
              prev_q  <= cur_q;
            end else begin
              state <= ST_CLK_HI;
            end
          end
        end
        ST_DONE: begin
          valid      <= 1'b0;
          input_data <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
